addr_seq: RTL and testbench

// - Addressing-mode sequencer sitting directly downstream of the MC6502 opcode decoder.
// - Takes the decoded ADDR_MODE, fetches operand/pointer bytes over the memory bus and produces the effective address.
// - Hands EA, OPERAND and PC_INC to the execute stage.

---
 rtl/addr_seq_pkg.sv | 33 +++
 rtl/addr_index_add.sv | 17 +
 rtl/addr_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_addr_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_seq_pkg.sv
// Shared widths, addressing-mode codes and small helpers for the addr_seq sequencer.
package addr_seq_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned HI_W    = ADDR_W - DATA_W;
    localparam int unsigned MODE_W  = 4;
    localparam int unsigned PCINC_W = 2;

    localparam logic [MODE_W-1:0] C_ADDR_MODE_IMP = 4'd0;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_ACC = 4'd1;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_IMM = 4'd2;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_REL = 4'd3;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_ZPG = 4'd4;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_ZPX = 4'd5;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_ZPY = 4'd6;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_ABS = 4'd7;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_ABX = 4'd8;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_ABY = 4'd9;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_IND = 4'd10;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_INX = 4'd11;
    localparam logic [MODE_W-1:0] C_ADDR_MODE_INY = 4'd12;

    // Modes that fetch at least one operand byte; undefined codes behave as IMP.
    function automatic logic mode_fetches(input logic [MODE_W-1:0] mode);
        return (mode >= C_ADDR_MODE_IMM) && (mode <= C_ADDR_MODE_INY);
    endfunction

    function automatic logic [ADDR_W-1:0] zp_addr(input logic [DATA_W-1:0] a);
        return {HI_W'(0), a};
    endfunction

endpackage

// File: rtl/addr_index_add.sv
// Combinational base + index adder; reports carry out of the low byte as a page crossing.
module addr_index_add
    import addr_seq_pkg::*;
(
    input  logic [ADDR_W-1:0] base_i,
    input  logic [DATA_W-1:0] idx_i,
    output logic [ADDR_W-1:0] sum_c_o,
    output logic              page_carry_c_o
);

    logic [DATA_W:0] lo_sum;

    assign lo_sum         = {1'b0, base_i[DATA_W-1:0]} + {1'b0, idx_i};
    assign page_carry_c_o = lo_sum[DATA_W];
    assign sum_c_o        = {base_i[ADDR_W-1:DATA_W] + HI_W'(page_carry_c_o), lo_sum[DATA_W-1:0]};

endmodule

// File: rtl/addr_seq.sv
// 6502 addressing-mode sequencer: fetches operand/pointer bytes and produces EA.
// ADDR_SEQ_IND_PAGE_FIX_EN selects a full 16-bit carry for the IND high-byte pointer.
module addr_seq
    import addr_seq_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [MODE_W-1:0]   addr_mode_i,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic [DATA_W-1:0]   x_i,
    input  logic [DATA_W-1:0]   y_i,
    input  logic                rdy_i,
    input  logic [DATA_W-1:0]   din_i,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic                bus_rd_o,
    output logic [ADDR_W-1:0]   ea_o,
    output logic [DATA_W-1:0]   operand_o,
    output logic [PCINC_W-1:0]  pc_inc_o,
    output logic                page_cross_o,
    output logic                done_o,
    output logic                busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OP_LO  = 3'd1,
        S_OP_HI  = 3'd2,
        S_PTR_LO = 3'd3,
        S_PTR_HI = 3'd4,
        S_FIN    = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                bus_rd_q, bus_rd_d;
    logic [ADDR_W-1:0]   ea_q, ea_d;
    logic [DATA_W-1:0]   operand_q, operand_d;
    logic [PCINC_W-1:0]  pc_inc_q, pc_inc_d;
    logic                page_cross_q, page_cross_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   zp_idx, zp_sum, abs_idx;
    logic [ADDR_W-1:0]   idx_sum, ind_hi_addr, page_hi_addr, hi_ptr_addr;
    logic                idx_carry;

    // Zero-page index: X for ZPX/INX, Y for ZPY, none otherwise.
    assign zp_idx = (mode_q == C_ADDR_MODE_ZPX || mode_q == C_ADDR_MODE_INX) ? x_i :
                    (mode_q == C_ADDR_MODE_ZPY) ? y_i : '0;
    assign zp_sum = din_i + zp_idx;

    assign abs_idx = (mode_q == C_ADDR_MODE_ABX) ? x_i :
                     (mode_q == C_ADDR_MODE_ABY || mode_q == C_ADDR_MODE_INY) ? y_i : '0;

    // The final byte always arrives on din_i with the low byte parked in lo_q.
    addr_index_add u_index_add (
        .base_i         ({din_i, lo_q}),
        .idx_i          (abs_idx),
        .sum_c_o        (idx_sum),
        .page_carry_c_o (idx_carry)
    );

`ifdef ADDR_SEQ_IND_PAGE_FIX_EN
    assign ind_hi_addr = ptr_q + ADDR_W'(1);
`else
    assign ind_hi_addr = {ptr_q[ADDR_W-1:DATA_W], ptr_q[DATA_W-1:0] + DATA_W'(1)};
`endif
    assign page_hi_addr = {ptr_q[ADDR_W-1:DATA_W], ptr_q[DATA_W-1:0] + DATA_W'(1)};
    assign hi_ptr_addr  = (mode_q == C_ADDR_MODE_IND) ? ind_hi_addr : page_hi_addr;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mode_d       = mode_q;
        ptr_d        = ptr_q;
        lo_d         = lo_q;
        bus_addr_d   = bus_addr_q;
        ea_d         = ea_q;
        operand_d    = operand_q;
        pc_inc_d     = pc_inc_q;
        page_cross_d = page_cross_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pc_d   = pc_i;
                    mode_d = addr_mode_i;
                    if (mode_fetches(addr_mode_i)) begin
                        state_d    = S_OP_LO;
                        bus_addr_d = pc_i;
                    end else begin
                        state_d      = S_FIN;
                        ea_d         = '0;
                        operand_d    = '0;
                        pc_inc_d     = '0;
                        page_cross_d = 1'b0;
                    end
                end
            end
            S_OP_LO: begin
                if (rdy_i) begin
                    lo_d = din_i;
                    case (mode_q)
                        C_ADDR_MODE_IMM, C_ADDR_MODE_REL: begin
                            state_d      = S_FIN;
                            operand_d    = din_i;
                            ea_d         = pc_q;
                            pc_inc_d     = PCINC_W'(1);
                            page_cross_d = 1'b0;
                        end
                        C_ADDR_MODE_ZPG, C_ADDR_MODE_ZPX, C_ADDR_MODE_ZPY: begin
                            state_d      = S_FIN;
                            operand_d    = '0;
                            ea_d         = zp_addr(zp_sum);
                            pc_inc_d     = PCINC_W'(1);
                            page_cross_d = 1'b0;
                        end
                        C_ADDR_MODE_INX, C_ADDR_MODE_INY: begin
                            state_d    = S_PTR_LO;
                            ptr_d      = zp_addr(zp_sum);
                            bus_addr_d = zp_addr(zp_sum);
                        end
                        default: begin
                            state_d    = S_OP_HI;
                            bus_addr_d = pc_q + ADDR_W'(1);
                        end
                    endcase
                end
            end
            S_OP_HI: begin
                if (rdy_i) begin
                    if (mode_q == C_ADDR_MODE_IND) begin
                        state_d    = S_PTR_LO;
                        ptr_d      = {din_i, lo_q};
                        bus_addr_d = {din_i, lo_q};
                    end else begin
                        state_d      = S_FIN;
                        operand_d    = '0;
                        ea_d         = idx_sum;
                        pc_inc_d     = PCINC_W'(2);
                        page_cross_d = idx_carry;
                    end
                end
            end
            S_PTR_LO: begin
                if (rdy_i) begin
                    state_d    = S_PTR_HI;
                    lo_d       = din_i;
                    bus_addr_d = hi_ptr_addr;
                end
            end
            S_PTR_HI: begin
                if (rdy_i) begin
                    state_d      = S_FIN;
                    operand_d    = '0;
                    ea_d         = idx_sum;
                    pc_inc_d     = (mode_q == C_ADDR_MODE_IND) ? PCINC_W'(2) : PCINC_W'(1);
                    page_cross_d = idx_carry;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bus_rd_d = (state_d == S_OP_LO) || (state_d == S_OP_HI) ||
                   (state_d == S_PTR_LO) || (state_d == S_PTR_HI);
        if (!bus_rd_d) begin
            bus_addr_d = '0;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            mode_q       <= '0;
            ptr_q        <= '0;
            lo_q         <= '0;
            bus_addr_q   <= '0;
            bus_rd_q     <= 1'b0;
            ea_q         <= '0;
            operand_q    <= '0;
            pc_inc_q     <= '0;
            page_cross_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mode_q       <= mode_d;
            ptr_q        <= ptr_d;
            lo_q         <= lo_d;
            bus_addr_q   <= bus_addr_d;
            bus_rd_q     <= bus_rd_d;
            ea_q         <= ea_d;
            operand_q    <= operand_d;
            pc_inc_q     <= pc_inc_d;
            page_cross_q <= page_cross_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus_addr_o   = bus_addr_q;
    assign bus_rd_o     = bus_rd_q;
    assign ea_o         = ea_q;
    assign operand_o    = operand_q;
    assign pc_inc_o     = pc_inc_q;
    assign page_cross_o = page_cross_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_addr_seq.sv
// Randomized and directed bench for addr_seq against a behavioural addressing-mode model.
module tb_addr_seq;
    import addr_seq_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i, start_i, rdy_i;
    logic [3:0]  addr_mode_i;
    logic [15:0] pc_i;
    logic [7:0]  x_i, y_i, din_i;
    logic [15:0] bus_addr_o, ea_o;
    logic        bus_rd_o, page_cross_o, done_o, busy_o;
    logic [7:0]  operand_o;
    logic [1:0]  pc_inc_o;

    logic [7:0]  mem [0:65535];
    int          errors = 0;
    int          checks = 0;

    int          exp_ea, exp_inc, exp_pcx, exp_opd, exp_lat;
    int          exp_reads[$];
    int          got_lat;

    always #5 clk_i = ~clk_i;
    assign din_i = mem[bus_addr_o];

    addr_seq dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .addr_mode_i  (addr_mode_i),
        .pc_i         (pc_i),
        .x_i          (x_i),
        .y_i          (y_i),
        .rdy_i        (rdy_i),
        .din_i        (din_i),
        .bus_addr_o   (bus_addr_o),
        .bus_rd_o     (bus_rd_o),
        .ea_o         (ea_o),
        .operand_o    (operand_o),
        .pc_inc_o     (pc_inc_o),
        .page_cross_o (page_cross_o),
        .done_o       (done_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rd(input int a);
        return int'(mem[16'(a)]);
    endfunction

    // Expected reads, EA and latency straight from the addressing-mode definitions.
    task automatic model(input int m, input int pc, input int x, input int y);
        int p1, zp, t, ptr, lo, hi, base, idx, ha;
        p1 = (pc + 1) % 65536;
        exp_reads.delete();
        exp_ea = 0; exp_inc = 0; exp_pcx = 0; exp_opd = 0; exp_lat = 1;
        case (m)
            2, 3: begin
                exp_reads.push_back(pc);
                exp_opd = rd(pc); exp_ea = pc; exp_inc = 1; exp_lat = 2;
            end
            4, 5, 6: begin
                idx = (m == 5) ? x : (m == 6) ? y : 0;
                exp_reads.push_back(pc);
                exp_ea = (rd(pc) + idx) % 256; exp_inc = 1; exp_lat = 2;
            end
            7, 8, 9: begin
                idx = (m == 8) ? x : (m == 9) ? y : 0;
                exp_reads.push_back(pc); exp_reads.push_back(p1);
                base = rd(p1) * 256 + rd(pc);
                exp_ea = (base + idx) % 65536;
                exp_pcx = ((base % 256) + idx >= 256) ? 1 : 0;
                exp_inc = 2; exp_lat = 3;
            end
            10: begin
                ptr = rd(p1) * 256 + rd(pc);
`ifdef ADDR_SEQ_IND_PAGE_FIX_EN
                ha = (ptr + 1) % 65536;
`else
                ha = (ptr / 256) * 256 + (ptr + 1) % 256;
`endif
                exp_reads.push_back(pc); exp_reads.push_back(p1);
                exp_reads.push_back(ptr); exp_reads.push_back(ha);
                exp_ea = rd(ha) * 256 + rd(ptr); exp_inc = 2; exp_lat = 5;
            end
            11: begin
                zp = rd(pc); t = (zp + x) % 256;
                exp_reads.push_back(pc); exp_reads.push_back(t); exp_reads.push_back((t + 1) % 256);
                exp_ea = rd((t + 1) % 256) * 256 + rd(t); exp_inc = 1; exp_lat = 4;
            end
            12: begin
                zp = rd(pc);
                exp_reads.push_back(pc); exp_reads.push_back(zp); exp_reads.push_back((zp + 1) % 256);
                lo = rd(zp); hi = rd((zp + 1) % 256);
                base = hi * 256 + lo;
                exp_ea = (base + y) % 65536;
                exp_pcx = (lo + y >= 256) ? 1 : 0;
                exp_inc = 1; exp_lat = 4;
            end
            default: ;
        endcase
    endtask

    // stall_mode: 0 none, 1 random RDY and stray START, 2 three-cycle stall on the second read.
    task automatic run_txn(input int m, input int pc, input int x, input int y,
                           input int stall_mode, input string name);
        int cyc, stalls, stall_cnt, hold_ea;
        int got_reads[$];
        model(m, pc, x, y);
        stalls = 0; stall_cnt = 0;
        @(negedge clk_i);
        start_i = 1'b1; addr_mode_i = 4'(m); pc_i = 16'(pc); x_i = 8'(x); y_i = 8'(y); rdy_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; pc_i = 16'($urandom);
        cyc = 1;
        while (cyc < 60) begin
            if (stall_mode == 1) begin
                start_i = 1'($urandom_range(0, 1));
                addr_mode_i = 4'($urandom);
            end
            if (bus_rd_o) begin
                if (stall_mode == 2 && got_reads.size() == 1 && stall_cnt < 3) begin
                    rdy_i = 1'b0;
                    stall_cnt++;
                    if (exp_reads.size() > 1) chk({name, " stall addr"}, int'(bus_addr_o), exp_reads[1]);
                end else if (stall_mode == 1) begin
                    rdy_i = ($urandom_range(0, 3) != 0);
                end else begin
                    rdy_i = 1'b1;
                end
                if (rdy_i) got_reads.push_back(int'(bus_addr_o));
                else stalls++;
            end else begin
                rdy_i = 1'($urandom_range(0, 1));
            end
            if (done_o) break;
            @(posedge clk_i); #1;
            cyc++;
        end
        got_lat = cyc;
        chk({name, " done cycle"}, cyc, exp_lat + stalls);
        chk({name, " ea"}, int'(ea_o), exp_ea);
        chk({name, " pc_inc"}, int'(pc_inc_o), exp_inc);
        chk({name, " page_cross"}, int'(page_cross_o), exp_pcx);
        chk({name, " busy at done"}, int'(busy_o), 1);
        if (m == 2 || m == 3) chk({name, " operand"}, int'(operand_o), exp_opd);
        chk({name, " read count"}, got_reads.size(), exp_reads.size());
        for (int i = 0; i < got_reads.size() && i < exp_reads.size(); i++)
            chk({name, " read addr"}, got_reads[i], exp_reads[i]);
        hold_ea = int'(ea_o);
        @(posedge clk_i); #1;
        start_i = 1'b0; rdy_i = 1'b1;
        chk({name, " done pulse"}, int'(done_o), 0);
        chk({name, " idle"}, int'(busy_o), 0);
        chk({name, " ea held"}, int'(ea_o), hold_ea);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, " bus_addr"}, int'(bus_addr_o), 0);
        chk({name, " bus_rd"}, int'(bus_rd_o), 0);
        chk({name, " ea"}, int'(ea_o), 0);
        chk({name, " operand"}, int'(operand_o), 0);
        chk({name, " pc_inc"}, int'(pc_inc_o), 0);
        chk({name, " page_cross"}, int'(page_cross_o), 0);
        chk({name, " done"}, int'(done_o), 0);
        chk({name, " busy"}, int'(busy_o), 0);
    endtask

    initial begin
        int m, pc;
        rst_n_i = 1'b0; start_i = 1'b0; addr_mode_i = '0; pc_i = '0;
        x_i = '0; y_i = '0; rdy_i = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        repeat (3) @(posedge clk_i);
        #1;
        chk_zero_outputs("reset");
        rst_n_i = 1'b1;

        mem[16'h0200] = 8'hF0;
        run_txn(5, 16'h0200, 8'h20, 8'h00, 0, "zpx");
        chk("zpx ea const", int'(ea_o), 16'h0010);
        chk("zpx lat const", got_lat, 2);

        mem[16'h3000] = 8'hF0; mem[16'h3001] = 8'h12;
        run_txn(9, 16'h3000, 8'h00, 8'h20, 0, "aby");
        chk("aby ea const", int'(ea_o), 16'h1310);
        chk("aby cross const", int'(page_cross_o), 1);

        mem[16'h4000] = 8'hFF; mem[16'h4001] = 8'h10;
        mem[16'h10FF] = 8'h34; mem[16'h1000] = 8'h12; mem[16'h1100] = 8'h56;
        run_txn(10, 16'h4000, 0, 0, 0, "ind");
`ifdef ADDR_SEQ_IND_PAGE_FIX_EN
        chk("ind ea const", int'(ea_o), 16'h5634);
`else
        chk("ind ea const", int'(ea_o), 16'h1234);
`endif

        mem[16'h5000] = 8'hFF; mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h20;
        run_txn(12, 16'h5000, 0, 8'h05, 0, "iny");
        chk("iny ea const", int'(ea_o), 16'h2005);

        run_txn(7, 16'h6000, 0, 0, 2, "abs_stall");
        chk("abs_stall lat const", got_lat, 6);

        run_txn(7, 16'hFFFF, 0, 0, 0, "abs_wrap");
        run_txn(0, 16'h1234, 0, 0, 0, "imp");
        run_txn(15, 16'h1234, 0, 0, 0, "undef");

        // Reset while INX sits in PTR_LO.
        @(negedge clk_i);
        start_i = 1'b1; addr_mode_i = 4'd11; pc_i = 16'h7000; x_i = 8'h04;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        chk("inx ptr_lo read", int'(bus_rd_o), 1);
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        chk_zero_outputs("midreset");
        repeat (4) begin
            @(posedge clk_i); #1;
            chk("midreset no done", int'(done_o), 0);
        end
        run_txn(2, 16'h7100, 0, 0, 0, "imm_after_reset");

        for (int n = 0; n < 150; n++) begin
            m  = $urandom_range(0, 15);
            pc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : int'(16'($urandom));
            mem[16'(pc)] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            mem[16'(pc + 1)] = 8'($urandom);
            run_txn(m, pc, int'(8'($urandom)), int'(8'($urandom)), $urandom_range(0, 1), "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
